// File: rtl/contador_param_if.sv
// Handshake-free control/status bundle for contador_param: the master drives
// the operation controls, the slave (counter) returns the count and flags.
interface contador_param_if #(
  parameter int WIDTH = 6
) ();
  logic             en;
  logic [1:0]       operacao;
  logic [WIDTH-1:0] valor;
  logic [WIDTH-1:0] step;
  logic             sat;
  logic [WIDTH-1:0] cont;
  logic             at_max;
  logic             at_min;
  logic             wrap_p;
  logic             sat_p;

  modport master (
    output en, operacao, valor, step, sat,
    input  cont, at_max, at_min, wrap_p, sat_p
  );

  modport slave (
    input  en, operacao, valor, step, sat,
    output cont, at_max, at_min, wrap_p, sat_p
  );
endinterface

// File: rtl/contador_param.sv
// Parametrised up/down counter with load, programmable step, terminal value
// MAX_VAL and run-time wrap (modulo MAX_VAL+1) or saturate behaviour.
module contador_param #(
  parameter int WIDTH     = 6,
  parameter int MAX_VAL   = (2**WIDTH)-1,
  parameter int RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              clr,
  contador_param_if.slave   bus
);

  if (WIDTH < 2) begin : g_chk_width
    $error("contador_param: WIDTH must be >= 2");
  end
  if ((MAX_VAL < 1) || (MAX_VAL > (2**WIDTH)-1)) begin : g_chk_max
    $error("contador_param: MAX_VAL outside 1..2**WIDTH-1");
  end
  if ((RESET_VAL < 0) || (RESET_VAL > MAX_VAL)) begin : g_chk_reset
    $error("contador_param: RESET_VAL outside 0..MAX_VAL");
  end

  // Arithmetic is done one bit wider so that cont+step never loses a carry.
  localparam logic [WIDTH:0]   MAX_E   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_E   = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cont_q, cont_d;
  logic             wrap_q, wrap_d;
  logic             sat_q,  sat_d;
  logic [WIDTH:0]   s_eff;
  logic [WIDTH:0]   cur;
  logic [WIDTH:0]   sum;

  function automatic logic [WIDTH:0] clamp_step(input logic [WIDTH-1:0] st);
    if ({1'b0, st} > MAX_E) begin
      clamp_step = MAX_E;
    end else begin
      clamp_step = {1'b0, st};
    end
  endfunction

  // Next-state: one wrap correction suffices because s_eff never exceeds MAX_VAL.
  always_comb begin
    cont_d = cont_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    s_eff  = clamp_step(bus.step);
    cur    = {1'b0, cont_q};
    sum    = cur + s_eff;
    if (!bus.en) begin
      cont_d = cont_q;
    end else begin
      case (bus.operacao)
        2'b00: cont_d = cont_q;
        2'b01: begin
          if ({1'b0, bus.valor} > MAX_E) begin
            cont_d = MAX_C;
            sat_d  = 1'b1;
          end else begin
            cont_d = bus.valor;
          end
        end
        2'b10: begin
          if (sum <= MAX_E) begin
            cont_d = WIDTH'(sum);
          end else if (bus.sat) begin
            cont_d = MAX_C;
            sat_d  = 1'b1;
          end else begin
            cont_d = WIDTH'(sum - MOD_E);
            wrap_d = 1'b1;
          end
        end
        2'b11: begin
          if (s_eff <= cur) begin
            cont_d = WIDTH'(cur - s_eff);
          end else if (bus.sat) begin
            cont_d = {WIDTH{1'b0}};
            sat_d  = 1'b1;
          end else begin
            cont_d = WIDTH'(cur + MOD_E - s_eff);
            wrap_d = 1'b1;
          end
        end
        default: cont_d = cont_q;
      endcase
    end
  end

  // State and event pulses, cleared synchronously by clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      cont_q <= RESET_C;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cont_q <= cont_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.cont   = cont_q;
  assign bus.wrap_p = wrap_q;
  assign bus.sat_p  = sat_q;
  assign bus.at_max = (cont_q == MAX_C);
  assign bus.at_min = (cont_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_contador_param.sv
// Directed table plus corner sequences for contador_param (6-bit, 0..59), with
// a second 4-bit instance (0..15, reset 5) tracked by a reference model throughout.
module tb_contador_param;
  localparam int W  = 6;
  localparam int M  = 59;
  localparam int W4 = 4;
  localparam int M4 = 15;
  localparam int R4 = 5;

  typedef struct {
    bit       c;
    bit       e;
    bit [1:0] op;
    int       v;
    int       st;
    bit       sa;
    int       ec;
    bit       ew;
    bit       es;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  contador_param_if #(.WIDTH(W))  bus  ();
  contador_param_if #(.WIDTH(W4)) bus4 ();

  contador_param #(.WIDTH(W),  .MAX_VAL(M),  .RESET_VAL(0))  dut  (.clk(clk), .clr(clr), .bus(bus));
  contador_param #(.WIDTH(W4), .MAX_VAL(M4), .RESET_VAL(R4)) dut4 (.clk(clk), .clr(clr), .bus(bus4));

  int  checks = 0;
  int  errors = 0;
  int  m6 = 0, m4 = 0;
  bit  w6, s6, w4, s4;
  bit  chk6_model = 1'b0;
  vec_t tbl[$];

  function automatic vec_t mk(bit c, bit e, bit [1:0] op, int v, int st, bit sa,
                              int ec, bit ew, bit es);
    vec_t r;
    r.c = c; r.e = e; r.op = op; r.v = v; r.st = st; r.sa = sa;
    r.ec = ec; r.ew = ew; r.es = es;
    return r;
  endfunction

  function automatic int ref_next(input int c, input bit cl, input bit en, input int op,
                                  input int v, input int st, input bit sa, input int mx,
                                  input int rv, output bit w, output bit s);
    int eff;
    int r;
    w = 1'b0; s = 1'b0; r = c;
    eff = (st > mx) ? mx : st;
    if (cl) r = rv;
    else if (en) begin
      case (op)
        1: if (v > mx) begin r = mx; s = 1'b1; end else r = v;
        2: if (c + eff > mx) begin
             if (sa) begin r = mx; s = 1'b1; end
             else begin r = c + eff - (mx + 1); w = 1'b1; end
           end else r = c + eff;
        3: if (eff > c) begin
             if (sa) begin r = 0; s = 1'b1; end
             else begin r = c + (mx + 1) - eff; w = 1'b1; end
           end else r = c - eff;
        default: r = c;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input bit c, input bit e, input bit [1:0] op, input int v,
                       input int st, input bit sa);
    clr = c;
    bus.en = e;  bus.operacao = op;  bus.valor = W'(v);  bus.step = W'(st);  bus.sat = sa;
    bus4.en = e; bus4.operacao = op; bus4.valor = W4'(v); bus4.step = W4'(st); bus4.sat = sa;
  endtask

  // One clock edge; the 4-bit instance is always compared with the model.
  task automatic tick();
    int n6, n4;
    n6 = ref_next(m6, clr, bus.en, int'(bus.operacao), int'(bus.valor), int'(bus.step),
                  bus.sat, M, 0, w6, s6);
    n4 = ref_next(m4, clr, bus4.en, int'(bus4.operacao), int'(bus4.valor), int'(bus4.step),
                  bus4.sat, M4, R4, w4, s4);
    @(posedge clk);
    #1;
    m6 = n6;
    m4 = n4;
    check("w4_cont",   int'(bus4.cont),   m4);
    check("w4_wrap",   int'(bus4.wrap_p), int'(w4));
    check("w4_sat",    int'(bus4.sat_p),  int'(s4));
    check("w4_at_max", int'(bus4.at_max), int'(m4 == M4));
    check("w4_at_min", int'(bus4.at_min), int'(m4 == 0));
    if (chk6_model) begin
      check("rnd_cont",  int'(bus.cont),   m6);
      check("rnd_wrap",  int'(bus.wrap_p), int'(w6));
      check("rnd_sat",   int'(bus.sat_p),  int'(s6));
      check("rnd_range", int'(bus.cont <= W'(M)), 1);
      check("rnd_excl",  int'(bus.wrap_p & bus.sat_p), 0);
    end
  endtask

  task automatic check6(input string name, input int ec, input bit ew, input bit es);
    check({name, "_cont"},   int'(bus.cont),   ec);
    check({name, "_wrap"},   int'(bus.wrap_p), int'(ew));
    check({name, "_sat"},    int'(bus.sat_p),  int'(es));
    check({name, "_at_max"}, int'(bus.at_max), int'(ec == M));
    check({name, "_at_min"}, int'(bus.at_min), int'(ec == 0));
  endtask

  initial begin
    int wraps;
    drive(1'b1, 1'b0, 2'b00, 0, 0, 1'b0);
    tick();
    tick();
    check6("reset", 0, 1'b0, 1'b0);

    // Full modulo-60 lap from 0: one wrap exactly when cont returns to 0.
    wraps = 0;
    drive(1'b0, 1'b1, 2'b10, 0, 1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.wrap_p) wraps++;
      if (i == 58) check6("lap_top", 59, 1'b0, 1'b0);
    end
    check6("lap_end", 0, 1'b1, 1'b0);
    check("lap_wraps", wraps, 1);

    tbl.push_back(mk(1, 0, 2'b00,  0,  0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 35,  0, 0, 35, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11,  0, 10, 0, 25, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11,  0, 10, 0, 15, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11,  0, 10, 0,  5, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11,  0, 10, 0, 55, 1, 0));
    tbl.push_back(mk(0, 1, 2'b11,  0, 10, 0, 45, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 63,  0, 0, 59, 0, 1));
    tbl.push_back(mk(0, 1, 2'b10,  0,  7, 1, 59, 0, 1));
    tbl.push_back(mk(0, 1, 2'b10,  0,  7, 1, 59, 0, 1));
    tbl.push_back(mk(0, 1, 2'b01,  3,  0, 0,  3, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11,  0, 63, 1,  0, 0, 1));
    tbl.push_back(mk(0, 1, 2'b01,  3,  0, 0,  3, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11,  0, 63, 0,  4, 1, 0));
    tbl.push_back(mk(0, 0, 2'b10,  0,  5, 0,  4, 0, 0));
    tbl.push_back(mk(0, 1, 2'b00,  0,  5, 0,  4, 0, 0));
    tbl.push_back(mk(0, 1, 2'b10,  0,  0, 0,  4, 0, 0));
    tbl.push_back(mk(0, 1, 2'b10,  0, 56, 0,  0, 1, 0));
    tbl.push_back(mk(0, 1, 2'b11,  0,  1, 0, 59, 1, 0));
    tbl.push_back(mk(0, 1, 2'b10,  0,  1, 0,  0, 1, 0));
    tbl.push_back(mk(0, 1, 2'b11,  0,  1, 1,  0, 0, 1));
    tbl.push_back(mk(0, 1, 2'b10,  0, 59, 1, 59, 0, 0));
    tbl.push_back(mk(0, 1, 2'b10,  0,  1, 1, 59, 0, 1));
    tbl.push_back(mk(1, 1, 2'b10,  0,  1, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 59,  0, 0, 59, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 60,  0, 0, 59, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11,  0, 59, 0,  0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].c, tbl[i].e, tbl[i].op, tbl[i].v, tbl[i].st, tbl[i].sa);
      tick();
      check6($sformatf("vec%0d", i), tbl[i].ec, tbl[i].ew, tbl[i].es);
    end

    // Enable low holds for several cycles with no pulses.
    drive(1'b0, 1'b1, 2'b01, 20, 0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'b10, 0, 5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check6($sformatf("hold%0d", i), 20, 1'b0, 1'b0);
    end

    // clr wins over an up-count that would otherwise wrap.
    drive(1'b0, 1'b1, 2'b01, 58, 0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 2'b10, 0, 1, 1'b0);
    tick();
    check6("pre_clr", 59, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b10, 0, 5, 1'b0);
    tick();
    check6("clr_wins", 0, 1'b0, 1'b0);

    // Random traffic against the model on both widths.
    chk6_model = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive(bit'($urandom_range(0, 49) == 0), bit'($urandom_range(0, 7) != 0),
            2'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6)),
            bit'($urandom_range(0, 1)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
